alu_iter_mult: RTL and testbench

- Execute-stage ALU of the single-issue MIPS pipeline.
- Consumes the 3-bit ALU control code from the ALU control decoder, together with the two register/immediate operands.
- Add, sub, and and or complete in one clock. Mult runs as a 32-iteration shift-add sequence, and busy_o stalls the pipeline until it finishes.
- The result is registered and qualified by valid_o for the EX/MEM register.

---
 rtl/alu_iter_mult.sv | 105 ++++++++++
 tb/tb_alu_iter_mult.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_mult.sv
// Execute-stage ALU: one-cycle add/sub/and/or plus an
// iterative shift-add multiplier that stalls the pipe via busy_o.
module alu_iter_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;
  logic             is_mul;
  logic             last_iter;

  assign is_mul    = (ALUCtrl_i == OP_MUL);
  assign last_iter = (counter == CW'(WIDTH - 1));
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  // Undefined codes fall through to add.
  always_comb begin
    alu_res = data1_i + data2_i;
    unique case (ALUCtrl_i)
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      default: alu_res = data1_i + data2_i;
    endcase
  end

  assign busy_o = (state == MUL) ||
                  (valid_i && is_mul);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      counter <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      data_o  <= '0;
      zero_o  <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i && is_mul) begin
            mcand   <= data1_i;
            mplier  <= data2_i;
            acc     <= '0;
            counter <= '0;
            state   <= MUL;
          end else if (valid_i) begin
            data_o  <= alu_res;
            zero_o  <= (alu_res == '0);
            valid_o <= 1'b1;
          end
        end
        MUL: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CW'(1);
          // Fixed WIDTH iterations; no early exit.
          if (last_iter) begin
            data_o  <= acc_next;
            zero_o  <= (acc_next == '0);
            valid_o <= 1'b1;
            counter <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_mult.sv
// Scoreboard bench for alu_iter_mult: expected results queued
// at issue, popped and compared whenever valid_o pulses.
module tb_alu_iter_mult;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [2:0]  ALUCtrl_i = '0;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;
  int run    = 0;
  int max_run = 0;

  logic [31:0] exp_q[$];

  alu_iter_mult #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data_o   (data_o),
    .zero_o   (zero_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Scoreboard side: compare each result pulse.
  always @(negedge clk_i) begin
    if (rst_i && valid_o) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("data", data_o, e);
        chk("zero", 32'(zero_o), 32'(e == 0));
      end
    end else begin
      run = 0;
    end
  end

  // Called at posedge+1; holds operands across one edge.
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] e);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_mul(input logic [31:0] a,
                        input logic [31:0] b,
                        input bit inj);
    int lat;
    int busy;
    lat  = -1;
    busy = 0;
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b011;
    data1_i   = a;
    data2_i   = b;
    exp_q.push_back(a * b);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        lat = c;
        break;
      end
      busy += int'(busy_o);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      if (inj && c == 9) begin
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b010;
        data1_i   = 32'd1;
        data2_i   = 32'd1;
      end
    end
    chk("mul_latency", 32'(lat), 32'd33);
    chk("mul_busy_cycles", 32'(busy), 32'd33);
    chk("busy_at_done", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_data", data_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    idle(2);

    issue(3'b010, 32'd5, 32'd7, 32'd12);
    @(negedge clk_i);
    chk("add_valid", 32'(valid_o), 32'd1);
    chk("add_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("add_pulse_end", 32'(valid_o), 32'd0);
    idle(1);

    max_run = 0;
    issue(3'b110, 32'd9, 32'd9, 32'd0);
    issue(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
    issue(3'b001, 32'h1, 32'h2, 32'h3);
    idle(3);
    chk("b2b_run", 32'(max_run), 32'd3);

    do_mul(32'd7, 32'd6, 1'b0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_mul(32'h10000, 32'h10000, 1'b0);
    do_mul(32'hFFFFFFF9, 32'd13, 1'b1);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      do_mul(a, b, 1'b0);
    end

    // Reset in the middle of a mult.
    issue(3'b001, 32'hA5, 32'h0, 32'hA5);
    idle(1);
    valid_i   = 1'b1;
    ALUCtrl_i = 3'b011;
    data1_i   = 32'd3;
    data2_i   = 32'd3;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    idle(14);
    rst_i = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_data", data_o, 32'd0);
    chk("midrst_zero", 32'(zero_o), 32'd1);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    idle(2);
    rst_i = 1'b1;
    idle(1);
    issue(3'b010, 32'd2, 32'd3, 32'd5);
    @(negedge clk_i);
    chk("post_rst_lat1", 32'(valid_o), 32'd1);
    idle(40);

    issue(3'b111, 32'd4, 32'd4, 32'd8);
    issue(3'b100, 32'd10, 32'd20, 32'd30);
    issue(3'b110, 32'd0, 32'd1, 32'hFFFFFFFF);
    idle(3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
